sequence_game_ctrl: RTL and testbench

//  Round controller for the memory-challenge game; consumes the 16x4 sync RAM holding the move sequence.

---
 rtl/sequence_game_ctrl.sv | 172 +++++++++++++++++
 tb/tb_sequence_game_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sequence_game_ctrl.sv
// rtl/sequence_game_ctrl.sv - memory-challenge round controller; optional press timeout under TIMEOUT_EN
module sequence_game_ctrl #(
    parameter int unsigned SHOW_CYCLES = 50_000_000,
    parameter int unsigned GAP_CYCLES  = 12_500_000,
    parameter int unsigned MAX_ROUNDS  = 16
`ifdef TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 250_000_000
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] buttons,
    output logic [3:0] ram_addr,
    input  logic [3:0] ram_q,
    output logic [3:0] leds,
    output logic [3:0] round,
    output logic       busy,
    output logic       won,
    output logic       lost,
    output logic       timeout
);

    typedef enum logic [3:0] {
        IDLE, F_SHOW, SHOW, GAP, F_CMP, WAIT_PRESS, WAIT_REL, WON, LOST
    } state_t;

    localparam logic [31:0] SHOW_LAST  = 32'(SHOW_CYCLES - 1);
    localparam logic [31:0] GAP_LAST   = 32'(GAP_CYCLES - 1);
    localparam logic [3:0]  LAST_ROUND = 4'(MAX_ROUNDS - 1);
`ifdef TIMEOUT_EN
    localparam logic [31:0] TO_LAST    = 32'(TIMEOUT_CYCLES - 1);
`endif

    state_t      state, state_n;
    logic [31:0] cnt, cnt_n;
    logic [3:0]  pos, pos_n;
    logic [3:0]  btn_prev;
    logic [3:0]  addr_n, leds_n, round_n;
    logic        busy_n, won_n, lost_n, timeout_n;
    logic        press, one_hot, match;

    // A press is the first cycle any button goes down after all were up.
    assign press   = (buttons != 4'd0) && (btn_prev == 4'd0);
    assign one_hot = (buttons != 4'd0) && ((buttons & (buttons - 4'd1)) == 4'd0);
    assign match   = one_hot && (buttons == ram_q);

    // Next-state and next-output logic; all outputs are registered below.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        pos_n     = pos;
        round_n   = round;
        addr_n    = ram_addr;
        leds_n    = leds;
        timeout_n = timeout;
        case (state)
            IDLE, WON, LOST: begin
                if (start) begin
                    state_n   = F_SHOW;
                    cnt_n     = 32'd0;
                    pos_n     = 4'd0;
                    round_n   = 4'd0;
                    addr_n    = 4'd0;
                    leds_n    = 4'd0;
                    timeout_n = 1'b0;
                end
            end
            F_SHOW: begin
                state_n = SHOW;
                cnt_n   = 32'd0;
                leds_n  = ram_q;
            end
            SHOW: begin
                if (cnt == SHOW_LAST) begin
                    state_n = GAP;
                    cnt_n   = 32'd0;
                    leds_n  = 4'd0;
                end else begin
                    cnt_n = cnt + 32'd1;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_n = 32'd0;
                    if (pos == round) begin
                        pos_n   = 4'd0;
                        addr_n  = 4'd0;
                        state_n = F_CMP;
                    end else begin
                        pos_n   = 4'(pos + 4'd1);
                        addr_n  = 4'(pos + 4'd1);
                        state_n = F_SHOW;
                    end
                end else begin
                    cnt_n = cnt + 32'd1;
                end
            end
            F_CMP: begin
                state_n = WAIT_PRESS;
                cnt_n   = 32'd0;
            end
            WAIT_PRESS: begin
                if (press) begin
                    state_n = match ? WAIT_REL : LOST;
                end
`ifdef TIMEOUT_EN
                else if (cnt == TO_LAST) begin
                    state_n   = LOST;
                    timeout_n = 1'b1;
                end else begin
                    cnt_n = cnt + 32'd1;
                end
`endif
            end
            WAIT_REL: begin
                if (buttons == 4'd0) begin
                    if (pos < round) begin
                        pos_n   = 4'(pos + 4'd1);
                        addr_n  = 4'(ram_addr + 4'd1);
                        state_n = F_CMP;
                    end else if (round == LAST_ROUND) begin
                        state_n = WON;
                    end else begin
                        round_n = 4'(round + 4'd1);
                        pos_n   = 4'd0;
                        addr_n  = 4'd0;
                        state_n = F_SHOW;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
`ifndef TIMEOUT_EN
        timeout_n = 1'b0;
`endif
        busy_n = !((state_n == IDLE) || (state_n == WON) || (state_n == LOST));
        won_n  = (state_n == WON);
        lost_n = (state_n == LOST);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 32'd0;
            pos      <= 4'd0;
            btn_prev <= 4'd0;
            ram_addr <= 4'd0;
            leds     <= 4'd0;
            round    <= 4'd0;
            busy     <= 1'b0;
            won      <= 1'b0;
            lost     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            pos      <= pos_n;
            btn_prev <= buttons;
            ram_addr <= addr_n;
            leds     <= leds_n;
            round    <= round_n;
            busy     <= busy_n;
            won      <= won_n;
            lost     <= lost_n;
            timeout  <= timeout_n;
        end
    end

endmodule

// File: tb/tb_sequence_game_ctrl.sv
// tb/tb_sequence_game_ctrl.sv - self-checking bench for sequence_game_ctrl
module tb_sequence_game_ctrl;

    localparam int SHOW = 4;
    localparam int GAP  = 2;
    localparam int MAXR = 3;
    localparam int TOUT = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [3:0] buttons = 4'd0;
    logic [3:0] ram_addr, ram_q, leds, round;
    logic       busy, won, lost, timeout;
    logic [3:0] mem [16];

    int total = 0;
    int bad = 0;

    assign ram_q = mem[ram_addr];

    sequence_game_ctrl #(
        .SHOW_CYCLES(SHOW),
        .GAP_CYCLES(GAP),
        .MAX_ROUNDS(MAXR)
`ifdef TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(TOUT)
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .buttons(buttons),
        .ram_addr(ram_addr),
        .ram_q(ram_q),
        .leds(leds),
        .round(round),
        .busy(busy),
        .won(won),
        .lost(lost),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load_spec_mem();
        for (int i = 0; i < 16; i++) mem[i] = 4'd0;
        mem[0] = 4'b0001;
        mem[1] = 4'b0010;
        mem[2] = 4'b0100;
    endtask

    task automatic do_reset();
        buttons = 4'd0;
        start   = 1'b0;
        reset   = 1'b1;
        tick();
        chk("rst_leds", leds, 0);
        chk("rst_round", round, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_flags", {busy, won, lost, timeout}, 0);
        reset = 1'b0;
        tick();
    endtask

    task automatic begin_game();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_flags", {won, lost, timeout}, 0);
    endtask

    // Expected led trace of round r from its F_SHOW cycle through F_CMP:
    // per entry one fetch cycle, SHOW lit cycles, GAP dark cycles; then one
    // fetch cycle before the press window. 'hold' goes onto buttons in the GAP.
    task automatic watch_round(input int r, input logic [3:0] hold);
        logic [3:0] exp_q[$];
        for (int k = 0; k <= r; k++) begin
            exp_q.push_back(4'd0);
            for (int i = 0; i < SHOW; i++) exp_q.push_back(mem[k]);
            for (int i = 0; i < GAP; i++) exp_q.push_back(4'd0);
        end
        exp_q.push_back(4'd0);
        chk("round_idx", round, r);
        chk("round_busy", busy, 1);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i >= exp_q.size() - 1 - GAP) buttons = hold;
            chk("leds", leds, exp_q[i]);
            tick();
        end
    endtask

    // Press v against entry expv at position k of round r; returns 1 when the game ended.
    task automatic press_release(input logic [3:0] v, input logic [3:0] expv,
                                 input int r, input int k, output bit ended);
        bit ok;
        ok = ($countones(v) == 1) && (v == expv);
        ended = 1'b0;
        buttons = v;
        tick();
        if (!ok) begin
            chk("bad_press_lost", lost, 1);
            chk("bad_press_busy", busy, 0);
            chk("bad_press_tmo", timeout, 0);
            buttons = 4'd0;
            tick();
            chk("lost_stays", lost, 1);
            ended = 1'b1;
            return;
        end
        chk("good_press_lost", lost, 0);
        chk("good_press_busy", busy, 1);
        repeat ($urandom_range(0, 2)) tick();
        buttons = 4'd0;
        tick();
        if (k < r) begin
            chk("fcmp_leds", leds, 0);
            tick();
        end else if (r == MAXR - 1) begin
            chk("won", won, 1);
            chk("won_busy", busy, 0);
            chk("won_round", round, MAXR - 1);
            ended = 1'b1;
        end
    endtask

    typedef struct {
        logic [3:0] btn;
        bit         exp_lost;
        bit         exp_busy;
    } vec_t;

    vec_t vecs[6];

    initial begin
        bit ended;
        vecs[0] = '{4'b0001, 1'b0, 1'b1};
        vecs[1] = '{4'b0011, 1'b1, 1'b0};
        vecs[2] = '{4'b0010, 1'b1, 1'b0};
        vecs[3] = '{4'b1000, 1'b1, 1'b0};
        vecs[4] = '{4'b1111, 1'b1, 1'b0};
        vecs[5] = '{4'b0101, 1'b1, 1'b0};

        load_spec_mem();
        do_reset();

        // Round-0 press table.
        foreach (vecs[i]) begin
            do_reset();
            begin_game();
            watch_round(0, 4'd0);
            buttons = vecs[i].btn;
            tick();
            chk("vec_lost", lost, vecs[i].exp_lost);
            chk("vec_busy", busy, vecs[i].exp_busy);
            buttons = 4'd0;
            tick();
        end

        // Full correct play, then restart from WON.
        do_reset();
        begin_game();
        for (int r = 0; r < MAXR; r++) begin
            watch_round(r, 4'd0);
            for (int k = 0; k <= r; k++) press_release(mem[k], mem[k], r, k, ended);
        end
        chk("won_leds", leds, 0);
        begin_game();
        chk("restart_won", won, 0);
        watch_round(0, 4'd0);

        // Round 1, wrong second press.
        do_reset();
        begin_game();
        watch_round(0, 4'd0);
        press_release(4'b0001, mem[0], 0, 0, ended);
        watch_round(1, 4'd0);
        press_release(4'b0001, mem[1 - 1], 1, 0, ended);
        press_release(4'b0100, mem[1], 1, 1, ended);
        chk("r1_lost_round", round, 1);

        // Buttons held from GAP into WAIT_PRESS are not a press; start held while busy is ignored.
        do_reset();
        start = 1'b1;
        tick();
        watch_round(0, 4'b0010);
        start = 1'b0;
        repeat (3) tick();
        chk("held_not_lost", lost, 0);
        chk("held_busy", busy, 1);
        buttons = 4'd0;
        tick();
        press_release(4'b0001, mem[0], 0, 0, ended);
        watch_round(1, 4'd0);

        // Reset in the middle of SHOW.
        do_reset();
        begin_game();
        repeat (3) tick();
        chk("mid_show_leds", leds, 1);
        reset = 1'b1;
        tick();
        chk("midrst_leds", leds, 0);
        chk("midrst_round", round, 0);
        chk("midrst_flags", {busy, won, lost, timeout}, 0);
        reset = 1'b0;
        repeat (2) tick();
        chk("midrst_idle", busy, 0);

`ifdef TIMEOUT_EN
        // No press for TOUT cycles in the press window.
        do_reset();
        begin_game();
        watch_round(0, 4'd0);
        repeat (TOUT - 1) tick();
        chk("tmo_not_yet", lost, 0);
        tick();
        chk("tmo_lost", lost, 1);
        chk("tmo_flag", timeout, 1);
        begin_game();
        chk("tmo_cleared", timeout, 0);
        // A press on the expiry cycle wins over the timeout.
        watch_round(0, 4'd0);
        repeat (TOUT - 1) tick();
        press_release(4'b0001, mem[0], 0, 0, ended);
        chk("tmo_press_wins", timeout, 0);
        watch_round(1, 4'd0);
`endif

        // Randomised games against the round/entry rules.
        for (int g = 0; g < 25; g++) begin
            for (int i = 0; i < 16; i++) begin
                int p;
                p = $urandom_range(0, 9);
                if (p == 0) mem[i] = 4'd0;
                else if (p == 1) mem[i] = 4'b0011;
                else mem[i] = 4'(1 << $urandom_range(0, 3));
            end
            buttons = 4'd0;
            tick();
            begin_game();
            ended = 1'b0;
            for (int r = 0; r < MAXR && !ended; r++) begin
                watch_round(r, 4'd0);
                for (int k = 0; k <= r && !ended; k++) begin
                    logic [3:0] v;
                    repeat ($urandom_range(0, 3)) tick();
                    v = ($urandom_range(0, 9) < 8) ? mem[k] : 4'($urandom_range(1, 15));
                    if (v == 4'd0) v = 4'($urandom_range(1, 15));
                    press_release(v, mem[k], r, k, ended);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
